// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory_management unit between two requesters.
// Port 0 is the processor load/store/fetch port, port 1 a secondary master
// (boot loader / debug DMA). One transaction is in flight at a time; the
// granted request's fields are frozen on the memory side until its done pulse.
// Optional build macro MEM_ARB_ROUND_ROBIN_EN: when defined, simultaneous
// pending requests alternate by last grant; when undefined, port 0 always wins.
`timescale 1ns/1ps

module mem_port_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  // requester port 0
  input  logic              m0_start,
  input  logic              m0_operation,
  input  logic [1:0]        m0_size,
  input  logic [2:0]        m0_extension,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_done,
  output logic [DATA_W-1:0] m0_rdata,
  // requester port 1
  input  logic              m1_start,
  input  logic              m1_operation,
  input  logic [1:0]        m1_size,
  input  logic [2:0]        m1_extension,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_done,
  output logic [DATA_W-1:0] m1_rdata,
  // memory_management side
  output logic              memory_start,
  input  logic              memory_done,
  output logic              sel_mem_operation,
  output logic [1:0]        sel_mem_size,
  output logic [2:0]        sel_mem_extension,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_o,
  input  logic [DATA_W-1:0] mem_i,
  // status
  output logic [1:0]        grant,
  output logic              overrun
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t     state;
  logic [1:0] start_now;
  logic [1:0] start_q;
  logic [1:0] rise;
  logic [1:0] hit;
  logic [1:0] accept;
  logic [1:0] pending;
  logic [1:0] clr;
  logic [1:0] pending_next;
  logic       win;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic       last_grant;
`endif

  // A start counts only on its rising edge; a start that lands while the same
  // port already has a request queued or in flight is dropped and flagged.
  assign start_now = {m1_start, m0_start};
  assign rise      = start_now & ~start_q;
  assign hit       = rise & (pending | grant);
  assign accept    = rise & ~hit;

  // Arbitration: pick which pending port is served next (0 = port 0).
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    win = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    if (pending == 2'b11) begin
      win = ~last_grant;
    end else begin
      win = ~pending[0];
    end
`else
    win = ~pending[0];
`endif
  end

  // Next pending set: drop the bit being granted, add freshly accepted starts.
  always_comb begin
    clr = 2'b00;
    if (state == S_IDLE && pending != 2'b00) begin
      clr = win ? 2'b10 : 2'b01;
    end
    pending_next = (pending & ~clr) | accept;
  end

  // Previous-cycle start levels for rising-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state is written with <= only, so every register in the
    // block sees the pre-edge values of the others, as real flops do.
    if (reset) begin
      start_q <= 2'b00;
    end else begin
      start_q <= start_now;
    end
  end

  // Request queue and the sticky protocol-error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= 2'b00;
      overrun <= 1'b0;
    end else begin
      pending <= pending_next;
      if (hit != 2'b00) begin
        overrun <= 1'b1;
      end
    end
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Remember which port got the most recent grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (state == S_IDLE && pending != 2'b00) begin
      last_grant <= win;
    end
  end
`endif

  // Transaction sequencer: every memory-side and response output is a flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= S_IDLE;
      grant             <= 2'b00;
      memory_start      <= 1'b0;
      m0_done           <= 1'b0;
      m1_done           <= 1'b0;
      m0_rdata          <= '0;
      m1_rdata          <= '0;
      sel_mem_operation <= 1'b0;
      sel_mem_size      <= 2'b00;
      sel_mem_extension <= 3'b000;
      addr              <= '0;
      data_o            <= '0;
    end else begin
      // Pulses default low; each state raises only what it owns.
      memory_start <= 1'b0;
      m0_done      <= 1'b0;
      m1_done      <= 1'b0;

      case (state)
        S_IDLE: begin
          if (pending != 2'b00) begin
            if (win) begin
              grant             <= 2'b10;
              sel_mem_operation <= m1_operation;
              sel_mem_size      <= m1_size;
              sel_mem_extension <= m1_extension;
              addr              <= m1_addr;
              data_o            <= m1_wdata;
            end else begin
              grant             <= 2'b01;
              sel_mem_operation <= m0_operation;
              sel_mem_size      <= m0_size;
              sel_mem_extension <= m0_extension;
              addr              <= m0_addr;
              data_o            <= m0_wdata;
            end
            // High for exactly the ISSUE cycle.
            memory_start <= 1'b1;
            state        <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          state <= S_WAIT;
        end

        S_WAIT: begin
          if (memory_done) begin
            // Stores leave the requester's read data untouched.
            if (grant[1]) begin
              m1_done <= 1'b1;
              if (!sel_mem_operation) begin
                m1_rdata <= mem_i;
              end
            end else begin
              m0_done <= 1'b1;
              if (!sel_mem_operation) begin
                m0_rdata <= mem_i;
              end
            end
            state <= S_RESP;
          end
        end

        S_RESP: begin
          grant <= 2'b00;
          state <= S_IDLE;
        end

        default: begin
          grant <= 2'b00;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small memory_management model
// that answers each memory_start after mem_lat cycles.
`timescale 1ns/1ps

module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        m0_start, m0_operation;
  logic [1:0]  m0_size;
  logic [2:0]  m0_extension;
  logic [63:0] m0_addr, m0_wdata;
  logic        m0_done;
  logic [63:0] m0_rdata;
  logic        m1_start, m1_operation;
  logic [1:0]  m1_size;
  logic [2:0]  m1_extension;
  logic [63:0] m1_addr, m1_wdata;
  logic        m1_done;
  logic [63:0] m1_rdata;
  logic        memory_start;
  logic        memory_done;
  logic        sel_mem_operation;
  logic [1:0]  sel_mem_size;
  logic [2:0]  sel_mem_extension;
  logic [63:0] addr, data_o, mem_i;
  logic [1:0]  grant;
  logic        overrun;

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk(clk), .reset(reset),
    .m0_start(m0_start), .m0_operation(m0_operation), .m0_size(m0_size),
    .m0_extension(m0_extension), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_done(m0_done), .m0_rdata(m0_rdata),
    .m1_start(m1_start), .m1_operation(m1_operation), .m1_size(m1_size),
    .m1_extension(m1_extension), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_done(m1_done), .m1_rdata(m1_rdata),
    .memory_start(memory_start), .memory_done(memory_done),
    .sel_mem_operation(sel_mem_operation), .sel_mem_size(sel_mem_size),
    .sel_mem_extension(sel_mem_extension), .addr(addr), .data_o(data_o),
    .mem_i(mem_i), .grant(grant), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec_cnt = 0;
  int miscmp  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miscmp++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // memory_management model and event monitor, sampled 1ns after each edge
  int          cyc_no      = 0;
  int          mstart_cnt  = 0;
  int          done0_cnt   = 0;
  int          done1_cnt   = 0;
  int          mstart_cyc  = 0;
  int          mdone_cyc   = 0;
  int          countdown   = 0;
  int          mem_lat     = 4;
  bit          model_on    = 1'b1;
  bit          inject_done = 1'b0;
  logic [63:0] mem_data    = '0;
  logic [63:0] addr_q[$];

  initial begin
    memory_done = 1'b0;
    mem_i       = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc_no++;
      memory_done = 1'b0;
      if (m0_done) done0_cnt++;
      if (m1_done) done1_cnt++;
      if (inject_done) begin
        memory_done = 1'b1;
        mem_i       = mem_data;
        inject_done = 1'b0;
      end
      if (memory_start) begin
        mstart_cnt++;
        mstart_cyc = cyc_no;
        addr_q.push_back(addr);
        if (model_on) countdown = mem_lat;
      end else if (countdown > 0) begin
        countdown--;
        if (countdown == 0) begin
          memory_done = 1'b1;
          mem_i       = mem_data;
          mdone_cyc   = cyc_no;
        end
      end
    end
  end

  task automatic wait_done(input bit port, output int n);
    bit seen;
    seen = 1'b0;
    n    = 0;
    while (!seen && n < 40) begin
      cyc();
      n++;
      seen = port ? m1_done : m0_done;
    end
    check(port ? "m1_done_timeout" : "m0_done_timeout", 64'(seen), 64'd1);
  endtask

  task automatic wait_total(input int target);
    int n;
    n = 0;
    while ((done0_cnt + done1_cnt) < target && n < 120) begin
      cyc();
      n++;
    end
    check("done_total_timeout", 64'(done0_cnt + done1_cnt), 64'(target));
  endtask

  logic [63:0] exp_order[5];
  int          n;
  int          base_d;
  int          base_ms;
  int          saved_done;
  int          snap0, snap1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    m0_start = 1'b0; m0_operation = 1'b0; m0_size = 2'b00; m0_extension = 3'b000;
    m0_addr = '0; m0_wdata = '0;
    m1_start = 1'b0; m1_operation = 1'b0; m1_size = 2'b00; m1_extension = 3'b000;
    m1_addr = '0; m1_wdata = '0;
    cyc(); cyc();

    // reset state
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_memory_start", 64'(memory_start), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);
    check("rst_addr", addr, 64'd0);
    check("rst_m0_rdata", m0_rdata, 64'd0);
    reset = 1'b0;
    cyc();

    // port 0 load
    m0_operation = 1'b0; m0_size = 2'b11; m0_extension = 3'b101; m0_addr = 64'h1000;
    mem_data = 64'hDEADBEEF_CAFEF00D;
    m0_start = 1'b1; cyc(); m0_start = 1'b0; cyc();
    check("t1_memory_start", 64'(memory_start), 64'd1);
    check("t1_grant", 64'(grant), 64'h1);
    check("t1_addr", addr, 64'h1000);
    check("t1_op", 64'(sel_mem_operation), 64'd0);
    check("t1_size", 64'(sel_mem_size), 64'h3);
    check("t1_ext", 64'(sel_mem_extension), 64'h5);
    wait_done(1'b0, n);
    check("t1_latency", 64'(n), 64'd5);
    check("t1_rdata", m0_rdata, 64'hDEADBEEF_CAFEF00D);
    check("t1_grant_resp", 64'(grant), 64'h1);
    cyc();
    check("t1_done_pulse", 64'(m0_done), 64'd0);
    check("t1_grant_idle", 64'(grant), 64'h0);

    // port 1 store
    m1_operation = 1'b1; m1_size = 2'b00; m1_addr = 64'h20; m1_wdata = 64'h55;
    mem_data = 64'h1234;
    m1_start = 1'b1; cyc(); m1_start = 1'b0; cyc();
    check("t2_grant", 64'(grant), 64'h2);
    check("t2_data_o", data_o, 64'h55);
    check("t2_op", 64'(sel_mem_operation), 64'd1);
    check("t2_addr", addr, 64'h20);
    wait_done(1'b1, n);
    check("t2_latency", 64'(n), 64'd5);
    check("t2_m1_rdata_kept", m1_rdata, 64'd0);
    check("t2_m0_rdata_kept", m0_rdata, 64'hDEADBEEF_CAFEF00D);
    cyc();

    // simultaneous starts, a lone port-0 access, simultaneous starts again
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_order = '{64'h100, 64'h200, 64'h300, 64'h200, 64'h100};
`else
    exp_order = '{64'h100, 64'h200, 64'h300, 64'h100, 64'h200};
`endif
    addr_q.delete();
    base_d = done0_cnt + done1_cnt;
    m0_operation = 1'b0; m1_operation = 1'b0; m0_addr = 64'h100; m1_addr = 64'h200;
    mem_data = 64'hA5A5;
    m0_start = 1'b1; m1_start = 1'b1; cyc(); m0_start = 1'b0; m1_start = 1'b0;
    wait_total(base_d + 2); cyc();
    m0_addr = 64'h300;
    m0_start = 1'b1; cyc(); m0_start = 1'b0;
    wait_total(base_d + 3); cyc();
    m0_addr = 64'h100;
    m0_start = 1'b1; m1_start = 1'b1; cyc(); m0_start = 1'b0; m1_start = 1'b0;
    wait_total(base_d + 5); cyc();
    check("t3_count", 64'(addr_q.size()), 64'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < addr_q.size()) check($sformatf("t3_order%0d", i), addr_q[i], exp_order[i]);
    end

    // port 1 arrives during port 0 WAIT
    m0_addr = 64'h400; mem_data = 64'h1111_2222_3333_4444;
    m0_start = 1'b1; cyc(); m0_start = 1'b0; cyc();
    cyc();
    m1_operation = 1'b0; m1_addr = 64'h500;
    m1_start = 1'b1; cyc(); m1_start = 1'b0;
    wait_done(1'b0, n);
    saved_done = mdone_cyc;
    mem_data = 64'h5555_6666_7777_8888;
    cyc();
    check("t4_idle_grant", 64'(grant), 64'h0);
    check("t4_idle_start", 64'(memory_start), 64'd0);
    cyc();
    check("t4_issue_start", 64'(memory_start), 64'd1);
    check("t4_issue_grant", 64'(grant), 64'h2);
    check("t4_issue_addr", addr, 64'h500);
    wait_done(1'b1, n);
    check("t4_gap", 64'(mstart_cyc - saved_done), 64'd3);
    check("t4_m0_rdata", m0_rdata, 64'h1111_2222_3333_4444);
    check("t4_m1_rdata", m1_rdata, 64'h5555_6666_7777_8888);
    cyc();

    // overrun: second m0 start while its request is still queued
    base_ms = mstart_cnt;
    base_d  = done0_cnt + done1_cnt;
    m1_addr = 64'h700; m0_addr = 64'h710; mem_data = 64'h0BAD_F00D;
    m1_start = 1'b1; cyc(); m1_start = 1'b0; cyc();
    cyc();
    m0_start = 1'b1; cyc(); m0_start = 1'b0; cyc();
    check("t5_overrun_before", 64'(overrun), 64'd0);
    m0_start = 1'b1; cyc(); m0_start = 1'b0;
    check("t5_overrun_set", 64'(overrun), 64'd1);
    wait_total(base_d + 2);
    repeat (6) cyc();
    check("t5_one_start", 64'(mstart_cnt - base_ms), 64'd2);
    check("t5_overrun_sticky", 64'(overrun), 64'd1);
    check("t5_m0_rdata", m0_rdata, 64'h0BAD_F00D);

    // reset in the middle of WAIT
    model_on = 1'b0;
    m0_addr = 64'h600;
    m0_start = 1'b1; cyc(); m0_start = 1'b0; cyc();
    cyc(); cyc();
    check("t6_in_wait_grant", 64'(grant), 64'h1);
    reset = 1'b1;
    #1;
    check("t6_grant", 64'(grant), 64'h0);
    check("t6_addr", addr, 64'h0);
    check("t6_m0_rdata", m0_rdata, 64'h0);
    check("t6_m1_rdata", m1_rdata, 64'h0);
    check("t6_overrun", 64'(overrun), 64'd0);
    cyc();
    reset = 1'b0;
    snap0 = done0_cnt; snap1 = done1_cnt; base_ms = mstart_cnt;
    cyc();
    inject_done = 1'b1;
    repeat (6) cyc();
    check("t6_no_done0", 64'(done0_cnt), 64'(snap0));
    check("t6_no_done1", 64'(done1_cnt), 64'(snap1));
    check("t6_no_start", 64'(mstart_cnt), 64'(base_ms));

    // normal service after reset
    model_on = 1'b1;
    m1_operation = 1'b0; m1_addr = 64'h800; mem_data = 64'hFEED_FACE_0000_0001;
    m1_start = 1'b1; cyc(); m1_start = 1'b0;
    wait_done(1'b1, n);
    check("t7_m1_rdata", m1_rdata, 64'hFEED_FACE_0000_0001);
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
    $finish;
  end

endmodule
